fir_out_quantizer: RTL and testbench
====================================

# fir_out_quantizer

Output stage placed directly downstream of the FIR filter in the DSP top level. It takes the full-precision FIR result (2·DATA_WIDTH+5 bits), applies a programmable arithmetic right shift with round-half-up, saturates to DATA_WIDTH, and buffers results in a small FIFO. It drives the top-level `dst_data_out` / `dst_valid_out` stream under valid/ready flow control, with no combinational path from `dst_ready_in` to `src_ready_out`.

## Interface
- `DATA_WIDTH`, 16: output sample width.
- `IN_WIDTH`, 2*DATA_WIDTH+5: FIR result width.
- `FIFO_DEPTH`, 4: output buffer entries; power of two, ≥2.
- `clk` in 1: single clock; all state on rising edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `shift` in 6: right-shift amount; values above IN_WIDTH-1 clamp to IN_WIDTH-1.
- `sat_clr` in 1: clears sticky `sat_flag` and the saturation counter.
- `src_data_in` in IN_WIDTH: signed FIR result.
- `src_valid_in` in 1: input valid.
- `src_ready_out` out 1: input ready.
- `dst_data_out` out DATA_WIDTH: signed quantized sample.
- `dst_valid_out` out 1: output valid.
- `dst_ready_in` in 1: downstream ready.
- `sat_flag` out 1: sticky; set on any saturated sample.
- `sat_count` out 16: saturation event count.

## Operation
- Accept occurs when `src_valid_in && src_ready_out`.
- Arithmetic on accept, with s = clamped `shift`:
  - Sign-extend the input to IN_WIDTH+1 bits.
  - If s>0, add 2^(s-1); then arithmetic right shift by s.
  - If the result exceeds 2^(DATA_WIDTH-1)-1, output 0x7FFF. If it is below -2^(DATA_WIDTH-1), output 0x8000. Either case is a saturation event.
- The quantized word is pushed into the FIFO in the same cycle as the accept; no separate pipeline register.
- `src_ready_out` = FIFO not full, decoded from the registered occupancy count only.
- Pop occurs when `dst_valid_out && dst_ready_in`. `dst_valid_out` = FIFO not empty. `dst_data_out` = head entry, held stable while `dst_valid_out && !dst_ready_in`.
- Simultaneous push and pop: occupancy unchanged; both pointers advance. When the FIFO is full, no push is possible in that cycle, even if a pop occurs.
- Pointers wrap modulo FIFO_DEPTH; occupancy ranges 0..FIFO_DEPTH.
- `sat_flag` is set in the cycle after an accept with saturation.
  - `sat_clr` clears it.
  - If `sat_clr` coincides with a saturating accept, set wins.
- `shift` is sampled per accept; a change affects the next accepted sample only. Buffered samples are unaffected.

## Timing
- Reset values: `src_ready_out`=1, `dst_valid_out`=0, `dst_data_out`=0, `sat_flag`=0, `sat_count`=0, occupancy=0.
- Latency: an input accepted at edge N is visible at `dst_*` after edge N (valid in cycle N+1) when the FIFO was empty.
- Throughput: 1 sample/cycle while `dst_ready_in`=1.
- With `dst_ready_in` held low, FIFO_DEPTH samples are accepted, then `src_ready_out` drops in the cycle after the last accept.
- `src_ready_out` rises in the cycle after the first pop from full.
- Reset mid-stream: all FIFO contents are discarded and outputs return to reset values asynchronously. Input data presented during reset is ignored.

## Configuration
- `PAK_DSP_SAT_CNT_EN` defined: `sat_count` is a 16-bit counter.
  - Increments on each saturating accept.
  - Saturates at 0xFFFF.
  - Cleared by `sat_clr`; if clear and increment coincide, the result is 1.
- `PAK_DSP_SAT_CNT_EN` undefined: the counter logic is absent and `sat_count` is tied to 0. `sat_flag` behaviour is unchanged.

## Structure
- `pak_dsp_pkg` holds:
  - the FIR output width constant (2*DATA_WIDTH+5);
  - the saturation limit constants;
  - a function `round_sat(value, shift)` that returns the quantized word and the saturation bit. The top-level FIR/width calculations share this function.
- One sub-module: `sync_fifo`, with parameters WIDTH and DEPTH, push/pop ports, full/empty flags, and a registered count. `fir_out_quantizer` holds only the arithmetic and the sat logic.

## Test plan
- Rounding: shift=4, inputs 0x18, 0x17, -0x18 → outputs 2, 1, -1. `sat_flag` stays 0.
- Saturation: shift=0, inputs 40000 and -40000 → outputs 0x7FFF and 0x8000. `sat_flag`=1. `sat_count`=2 with the macro, 0 without.
- Backpressure, depth 4: `dst_ready_in`=0, stream 1..6 → 4 accepted, `src_ready_out`=0. Release `dst_ready_in` → outputs 1,2,3,4 in order, then 5,6 after they are accepted, with no loss or duplication.
- Full throughput: continuous valid/ready for 100 samples at shift=8 → 100 outputs, one per cycle, latency 1.
- Clear race: `sat_clr` asserted in the same cycle as a saturating accept → `sat_flag`=1 and `sat_count`=1 (macro defined). A following `sat_clr` → both 0.
- Reset mid-stream: with 3 entries buffered, pulse `arst_n` low → `dst_valid_out`=0 immediately, `src_ready_out`=1, and the next accepted sample is the first output.

Source files
------------

// File: rtl/pak_dsp_pkg.sv
// Shared DSP constants and the FIR output quantization helper.
// Widths here are the reference for fir_out_quantizer; the round/saturate
// function is reused by other width calculations in the DSP top level.
package pak_dsp_pkg;

  localparam int DSP_DATA_WIDTH = 16;
  localparam int FIR_OUT_WIDTH  = 2 * DSP_DATA_WIDTH + 5;
  localparam int EXT_WIDTH      = FIR_OUT_WIDTH + 1;
  localparam int SHIFT_WIDTH    = 6;

  localparam logic [SHIFT_WIDTH-1:0] SHIFT_MAX = SHIFT_WIDTH'(FIR_OUT_WIDTH - 1);

  // Saturation limits in the extended (IN_WIDTH+1) domain, and the clipped words.
  localparam logic signed [EXT_WIDTH-1:0] SAT_POS_LIMIT = EXT_WIDTH'((1 << (DSP_DATA_WIDTH - 1)) - 1);
  localparam logic signed [EXT_WIDTH-1:0] SAT_NEG_LIMIT = EXT_WIDTH'(-(1 << (DSP_DATA_WIDTH - 1)));
  localparam logic [DSP_DATA_WIDTH-1:0]   SAT_POS_WORD  = {1'b0, {(DSP_DATA_WIDTH-1){1'b1}}};
  localparam logic [DSP_DATA_WIDTH-1:0]   SAT_NEG_WORD  = {1'b1, {(DSP_DATA_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic                      sat;
    logic [DSP_DATA_WIDTH-1:0] data;
  } quant_t;

  // Round-half-up arithmetic right shift followed by saturation to DSP_DATA_WIDTH.
  // The extra MSB keeps the rounding add from overflowing at the largest input.
  function automatic quant_t round_sat(input logic signed [FIR_OUT_WIDTH-1:0] value,
                                       input logic [SHIFT_WIDTH-1:0] shift);
    logic [SHIFT_WIDTH-1:0]      s;
    logic signed [EXT_WIDTH-1:0] ext;
    logic signed [EXT_WIDTH-1:0] acc;
    quant_t                      q;
    s   = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
    ext = EXT_WIDTH'(value);
    acc = ext;
    if (s != '0) begin
      acc = ext + (EXT_WIDTH'(1) << (s - SHIFT_WIDTH'(1)));
    end
    acc = acc >>> s;
    if (acc > SAT_POS_LIMIT) begin
      q.sat  = 1'b1;
      q.data = SAT_POS_WORD;
    end else if (acc < SAT_NEG_LIMIT) begin
      q.sat  = 1'b1;
      q.data = SAT_NEG_WORD;
    end else begin
      q.sat  = 1'b0;
      q.data = acc[DSP_DATA_WIDTH-1:0];
    end
    return q;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count. full/empty are decoded
// from the count register only, so they carry no combinational input path.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fir_out_quantizer.sv
// FIR output stage: round-half-up shift, saturate to DATA_WIDTH, buffer in a
// small FIFO and drive the downstream valid/ready stream.
// Optional feature macro: PAK_DSP_SAT_CNT_EN enables the 16-bit saturation
// event counter; without it sat_count is tied to 0.
// DATA_WIDTH/IN_WIDTH must match the pak_dsp_pkg constants used by round_sat.
module fir_out_quantizer
  import pak_dsp_pkg::*;
#(
  parameter int DATA_WIDTH = DSP_DATA_WIDTH,
  parameter int IN_WIDTH   = FIR_OUT_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [5:0]            shift,
  input  logic                  sat_clr,
  input  logic [IN_WIDTH-1:0]   src_data_in,
  input  logic                  src_valid_in,
  output logic                  src_ready_out,
  output logic [DATA_WIDTH-1:0] dst_data_out,
  output logic                  dst_valid_out,
  input  logic                  dst_ready_in,
  output logic                  sat_flag,
  output logic [15:0]           sat_count
);

  quant_t quant;
  logic   accept;
  logic   sat_event;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   sat_flag_q, sat_flag_d;

  assign accept        = src_valid_in && src_ready_out;
  assign sat_event     = accept && quant.sat;
  assign src_ready_out = !fifo_full;
  assign dst_valid_out = !fifo_empty;
  assign pop           = dst_valid_out && dst_ready_in;
  assign sat_flag      = sat_flag_q;

  // Quantize the incoming sample with the shift seen in the accept cycle.
  always_comb begin
    quant = round_sat(src_data_in, shift);
  end

  // Quantized word goes straight into the buffer on accept.
  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (accept),
    .wdata  (quant.data),
    .pop    (pop),
    .rdata  (dst_data_out),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Sticky saturation flag; a saturating accept wins over a coincident clear.
  always_comb begin
    sat_flag_d = sat_flag_q;
    if (sat_clr) begin
      sat_flag_d = 1'b0;
    end
    if (sat_event) begin
      sat_flag_d = 1'b1;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sat_flag_q <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
    end
  end

`ifdef PAK_DSP_SAT_CNT_EN
  logic [15:0] sat_count_q, sat_count_d;

  // Saturating event counter; clear plus increment in one cycle leaves 1.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end
    if (sat_event) begin
      if (sat_clr) begin
        sat_count_d = 16'd1;
      end else if (sat_count_q != 16'hFFFF) begin
        sat_count_d = sat_count_q + 16'd1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Self-checking bench for fir_out_quantizer: table-driven quantization vectors,
// a scoreboard queue for the output stream, and hand-written flow-control,
// clear-race and reset sequences.
module tb_fir_out_quantizer;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic [5:0]  shift = '0;
  logic        sat_clr = 1'b0;
  logic [36:0] src_data_in = '0;
  logic        src_valid_in = 1'b0;
  logic        src_ready_out;
  logic [15:0] dst_data_out;
  logic        dst_valid_out;
  logic        dst_ready_in = 1'b1;
  logic        sat_flag;
  logic [15:0] sat_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int out_cnt = 0;

  typedef struct {
    logic [15:0] data;
    int          exp_cyc;
    bit          chk_lat;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [36:0] din;
    logic [5:0]  sh;
    logic [15:0] exp;
    bit          sat;
  } vec_t;
  vec_t tbl[16];

  fir_out_quantizer dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .shift         (shift),
    .sat_clr       (sat_clr),
    .src_data_in   (src_data_in),
    .src_valid_in  (src_valid_in),
    .src_ready_out (src_ready_out),
    .dst_data_out  (dst_data_out),
    .dst_valid_out (dst_valid_out),
    .dst_ready_in  (dst_ready_in),
    .sat_flag      (sat_flag),
    .sat_count     (sat_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference quantizer written directly from the arithmetic definition.
  function automatic logic [15:0] model(input longint v, input int sh);
    int     s;
    longint r;
    s = (sh > 36) ? 36 : sh;
    r = v;
    if (s > 0) r = r + (longint'(1) <<< (s - 1));
    r = r >>> s;
    if (r > 32767) return 16'h7FFF;
    if (r < -32768) return 16'h8000;
    return r[15:0];
  endfunction

  // Output monitor: every downstream handshake pops and checks the scoreboard.
  always @(negedge clk) begin
    if (!arst_n) begin
      sb.delete();
    end else if (dst_valid_out && dst_ready_in) begin
      out_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got=%h expected=none", dst_data_out);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("out_data", longint'(dst_data_out), longint'(e.data));
        if (e.chk_lat) chk("out_cycle", cyc, e.exp_cyc);
      end
    end
  end

  // Drive one sample, hold until accepted, then queue its expected result.
  task automatic send(input logic [36:0] d, input logic [5:0] sh,
                      input logic [15:0] exp, input bit lat);
    bit acc;
    int n;
    src_data_in  = d;
    shift        = sh;
    src_valid_in = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = src_ready_out;
      @(posedge clk);
      #1;
      n++;
    end
    src_valid_in = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got=not_accepted expected=accepted");
    end else begin
      sb.push_back('{exp, cyc, lat});
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n_sat;
    longint exp_cnt;
    longint v;
    logic [36:0] d;
    logic [15:0] held;

    // rows 0..10 do not saturate, rows 11..15 do
    tbl[0]  = '{37'h18,          6'd4,  16'd2,      1'b0};
    tbl[1]  = '{37'h17,          6'd4,  16'd1,      1'b0};
    tbl[2]  = '{37'(-24),        6'd4,  16'hFFFF,   1'b0};
    tbl[3]  = '{37'd3,           6'd1,  16'd2,      1'b0};
    tbl[4]  = '{37'(-3),         6'd1,  16'hFFFF,   1'b0};
    tbl[5]  = '{37'd32767,       6'd0,  16'h7FFF,   1'b0};
    tbl[6]  = '{37'(-32768),     6'd0,  16'h8000,   1'b0};
    tbl[7]  = '{37'h0FFFFFFFFF,  6'd63, 16'd1,      1'b0};
    tbl[8]  = '{37'h1000000000,  6'd40, 16'hFFFF,   1'b0};
    tbl[9]  = '{37'h0800000000,  6'd36, 16'd1,      1'b0};
    tbl[10] = '{37'(-8388736),   6'd8,  16'h8000,   1'b0};
    tbl[11] = '{37'd40000,       6'd0,  16'h7FFF,   1'b1};
    tbl[12] = '{37'(-40000),     6'd0,  16'h8000,   1'b1};
    tbl[13] = '{37'd32768,       6'd0,  16'h7FFF,   1'b1};
    tbl[14] = '{37'h7FFFFF,      6'd8,  16'h7FFF,   1'b1};
    tbl[15] = '{37'(-8388737),   6'd8,  16'h8000,   1'b1};

    // reset values
    #1 arst_n = 1'b0;
    #2;
    chk("rst_src_ready", src_ready_out, 1);
    chk("rst_dst_valid", dst_valid_out, 0);
    chk("rst_dst_data", dst_data_out, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_sat_count", sat_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk);
    #1;

    // non-saturating vectors: rounding, exact limits, shift clamp
    for (int i = 0; i < 11; i++) send(tbl[i].din, tbl[i].sh, tbl[i].exp, 1'b1);
    drain();
    chk("sat_flag_after_rounding", sat_flag, 0);
    chk("sat_count_after_rounding", sat_count, 0);

    // saturating vectors
    n_sat = 0;
    for (int i = 11; i < 16; i++) begin
      send(tbl[i].din, tbl[i].sh, tbl[i].exp, 1'b1);
      if (tbl[i].sat) n_sat++;
    end
    drain();
`ifdef PAK_DSP_SAT_CNT_EN
    exp_cnt = n_sat;
`else
    exp_cnt = 0;
`endif
    chk("sat_flag_after_sat", sat_flag, 1);
    chk("sat_count_after_sat", sat_count, exp_cnt);

    // clear race: clear coincides with a saturating accept
    sat_clr = 1'b1;
    send(37'd40000, 6'd0, 16'h7FFF, 1'b1);
    sat_clr = 1'b0;
    #1;
    chk("race_sat_flag", sat_flag, 1);
`ifdef PAK_DSP_SAT_CNT_EN
    chk("race_sat_count", sat_count, 1);
`else
    chk("race_sat_count", sat_count, 0);
`endif
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    chk("clr_sat_flag", sat_flag, 0);
    chk("clr_sat_count", sat_count, 0);
    drain();

    // backpressure with depth 4
    dst_ready_in = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(37'(i), 6'd0, 16'(i), 1'b0);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        chk("bp_src_ready_full", src_ready_out, 0);
        chk("bp_dst_valid", dst_valid_out, 1);
        held = dst_data_out;
        chk("bp_head_data", dst_data_out, 1);
        @(posedge clk);
        #1;
        chk("bp_head_stable", dst_data_out, held);
        dst_ready_in = 1'b1;
        @(negedge clk);
        chk("bp_ready_before_pop", src_ready_out, 0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_after_pop", src_ready_out, 1);
      end
    join
    drain();
    chk("bp_out_count", out_cnt, 11 + 5 + 1 + 6);

    // full throughput: one output per cycle, one cycle after each accept
    for (int i = 0; i < 100; i++) begin
      v = $signed({$urandom, $urandom}) >>> $urandom_range(27, 50);
      d = v[36:0];
      send(d, 6'd8, model($signed(d), 8), 1'b1);
    end
    drain();
    chk("tp_out_count", out_cnt, 11 + 5 + 1 + 6 + 100);

    // reset mid-stream with three entries buffered
    dst_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) send(37'(100 + i), 6'd0, 16'(100 + i), 1'b0);
    chk("pre_rst_dst_valid", dst_valid_out, 1);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_dst_valid", dst_valid_out, 0);
    chk("mid_rst_src_ready", src_ready_out, 1);
    chk("mid_rst_dst_data", dst_data_out, 0);
    src_data_in  = 37'd999;
    src_valid_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n       = 1'b1;
    src_valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_dst_valid", dst_valid_out, 0);
    dst_ready_in = 1'b1;
    send(37'd5, 6'd0, 16'd5, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
